// File: rtl/memory_unit_if.sv
// Control strobes and program-loader handshake between the memory unit and
// its neighbours. The shared data bus is a tri-state net and stays a plain
// inout port on the memory unit.
// Optional macro LOADER_CHECKSUM_EN adds the load_sum signal.
interface memory_unit_if #(
    parameter int ADDR_W = 4
);
    // decoder strobes
    logic              mem_write_addr;
    logic              mem_read;
    logic              mem_write;
    // loader stream
    logic              load_start;
    logic              load_valid;
    logic [7:0]        load_data;
    logic              load_last;
    logic              load_ready;
    logic              load_done;
    logic              cpu_hold;
    logic [ADDR_W-1:0] load_count;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        load_sum;

    modport master (
        output mem_write_addr, mem_read, mem_write,
        output load_start, load_valid, load_data, load_last,
        input  load_ready, load_done, cpu_hold, load_count, load_sum
    );
    modport slave (
        input  mem_write_addr, mem_read, mem_write,
        input  load_start, load_valid, load_data, load_last,
        output load_ready, load_done, cpu_hold, load_count, load_sum
    );
`else
    modport master (
        output mem_write_addr, mem_read, mem_write,
        output load_start, load_valid, load_data, load_last,
        input  load_ready, load_done, cpu_hold, load_count
    );
    modport slave (
        input  mem_write_addr, mem_read, mem_write,
        input  load_start, load_valid, load_data, load_last,
        output load_ready, load_done, cpu_hold, load_count
    );
`endif
endinterface

// File: rtl/memory_unit.sv
// Main RAM + MAR on the shared 8-bit bus, with a byte-stream program loader
// that fills RAM from address 0 while the CPU is held.
// Optional macro LOADER_CHECKSUM_EN: running mod-256 sum of loaded bytes.
module memory_unit #(
    parameter int ADDR_W = 4
) (
    input  logic     clock,
    input  logic     reset_n,
    inout  wire [7:0] bus,
    memory_unit_if.slave mif
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] mar;
    logic [ADDR_W-1:0] load_count;
    logic [7:0]        ram [DEPTH];
    logic              load_ready, load_done, cpu_hold;
    logic              cpu_en, hs, rd_en, load_end;

    // CPU strobes only act in IDLE, and a coincident load_start drops them
    assign cpu_en   = (state == IDLE) && !mif.load_start;
    assign hs       = mif.load_valid && load_ready;
    assign load_end = hs && (mif.load_last || load_count == ADDR_W'(DEPTH - 1));
    // a simultaneous write owns the bus, so the read never drives it
    assign rd_en    = cpu_en && mif.mem_read && !mif.mem_write;
    assign bus      = rd_en ? ram[mar] : 8'hzz;

    // next-state and loader status outputs
    always_comb begin
        state_n    = state;
        load_ready = 1'b0;
        load_done  = 1'b0;
        cpu_hold   = 1'b1;
        case (state)
            IDLE: begin
                cpu_hold = 1'b0;
                if (mif.load_start) state_n = LOAD;
            end
            LOAD: begin
                load_ready = 1'b1;
                if (load_end) state_n = DONE;
            end
            DONE: begin
                load_done = 1'b1;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // state, MAR and loader address registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            mar        <= '0;
            load_count <= '0;
        end else begin
            state <= state_n;
            // DONE clears MAR so the CPU restarts fetching from 0
            if (state == DONE)
                mar <= '0;
            else if (cpu_en && mif.mem_write_addr)
                mar <= bus[ADDR_W-1:0];
            if (state == IDLE && mif.load_start)
                load_count <= '0;
            else if (hs)
                load_count <= load_count + 1'b1;   // wraps mod DEPTH
        end
    end

    // RAM write port; contents are deliberately not reset
    always_ff @(posedge clock) begin
        if (hs)
            ram[load_count] <= mif.load_data;
        else if (cpu_en && mif.mem_write)
            ram[mar] <= bus;   // uses the old MAR if write_addr is also set
    end

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] load_sum;

    // running checksum of loaded bytes, held after the load finishes
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            load_sum <= '0;
        else if (state == IDLE && mif.load_start)
            load_sum <= '0;
        else if (hs)
            load_sum <= load_sum + mif.load_data;
    end

    assign mif.load_sum = load_sum;
`endif

    assign mif.load_ready = load_ready;
    assign mif.load_done  = load_done;
    assign mif.cpu_hold   = cpu_hold;
    assign mif.load_count = load_count;
endmodule

// File: tb/tb_memory_unit.sv
// Directed bench for memory_unit. Stimulus pushes expected read data and
// expected load-completion results into queues; a monitor on the falling
// edge pops and compares whenever the DUT drives a read or pulses load_done.
module tb_memory_unit;
    localparam int ADDR_W = 4;

    typedef struct {
        logic [ADDR_W-1:0] cnt;
        logic [7:0]        sum;
    } done_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] bus_drv = 8'h00;
    logic       bus_oe = 1'b0;
    wire  [7:0] bus;

    int checks = 0;
    int errors = 0;

    logic [7:0] rd_q[$];
    done_t      done_q[$];

    memory_unit_if #(.ADDR_W(ADDR_W)) mif ();

    assign bus = bus_oe ? bus_drv : 8'hzz;

    memory_unit #(.ADDR_W(ADDR_W)) dut (
        .clock  (clk),
        .reset_n(rst_n),
        .bus    (bus),
        .mif    (mif)
    );

    always #5 clk = ~clk;

    // undriven bus reads as z in 4-state simulators and 0 in 2-state ones
    function automatic bit bus_idle();
        return (bus === 8'hzz) || (bus === 8'h00);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (!bus_idle()) begin
            errors++;
            $display("FAIL %s: bus driven with %0h expected undriven", name, bus);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobes_off();
        mif.mem_write_addr = 1'b0;
        mif.mem_read       = 1'b0;
        mif.mem_write      = 1'b0;
        bus_oe             = 1'b0;
    endtask

    task automatic set_mar(input logic [7:0] v);
        bus_drv = v; bus_oe = 1'b1; mif.mem_write_addr = 1'b1;
        tick();
        strobes_off();
    endtask

    task automatic wr(input logic [7:0] v);
        bus_drv = v; bus_oe = 1'b1; mif.mem_write = 1'b1;
        tick();
        strobes_off();
    endtask

    task automatic rd(input logic [7:0] exp);
        rd_q.push_back(exp);
        mif.mem_read = 1'b1;
        tick();
        strobes_off();
    endtask

    task automatic load(input logic [7:0] d, input bit last);
        mif.load_valid = 1'b1; mif.load_data = d; mif.load_last = last;
        tick();
        mif.load_valid = 1'b0; mif.load_last = 1'b0;
    endtask

    task automatic start_load();
        mif.load_start = 1'b1;
        tick();
        mif.load_start = 1'b0;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (mif.mem_read && !mif.mem_write && !mif.load_start && !mif.cpu_hold) begin
                checks++;
                if (rd_q.size() == 0) begin
                    errors++;
                    $display("FAIL read: unexpected read, bus %0h", bus);
                end else begin
                    logic [7:0] e;
                    e = rd_q.pop_front();
                    if (bus !== e) begin
                        errors++;
                        $display("FAIL read: got %0h expected %0h", bus, e);
                    end
                end
            end
            if (mif.load_done) begin
                checks++;
                if (done_q.size() == 0) begin
                    errors++;
                    $display("FAIL load_done: unexpected pulse");
                end else begin
                    done_t e;
                    e = done_q.pop_front();
                    if (mif.load_count !== e.cnt) begin
                        errors++;
                        $display("FAIL done_count: got %0h expected %0h", mif.load_count, e.cnt);
                    end
`ifdef LOADER_CHECKSUM_EN
                    checks++;
                    if (mif.load_sum !== e.sum) begin
                        errors++;
                        $display("FAIL load_sum: got %0h expected %0h", mif.load_sum, e.sum);
                    end
`endif
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        strobes_off();
        mif.load_start = 1'b0; mif.load_valid = 1'b0;
        mif.load_data = 8'h00; mif.load_last = 1'b0;
        tick(); tick();
        // reset state
        check("rst_cpu_hold", 32'(mif.cpu_hold), 32'h0);
        check("rst_load_ready", 32'(mif.load_ready), 32'h0);
        check("rst_load_done", 32'(mif.load_done), 32'h0);
        check("rst_load_count", 32'(mif.load_count), 32'h0);
        check_idle("rst_bus");
        rst_n = 1'b1;
        tick();

        // MAR resets to 0: unaddressed write lands at 0
        wr(8'hA5);
        set_mar(8'h30);                 // upper nibble ignored -> addr 0
        rd(8'hA5);

        // basic write/read with upper address bits ignored
        set_mar(8'h3A);
        wr(8'h5C);
        rd(8'h5C);

        // read+write together: write wins
        bus_drv = 8'h77; bus_oe = 1'b1; mif.mem_write = 1'b1; mif.mem_read = 1'b1;
        tick(); strobes_off();
        rd(8'h77);

        // write_addr+write together: write uses old MAR
        set_mar(8'h06); wr(8'h99);
        set_mar(8'h0A);
        bus_drv = 8'h46; bus_oe = 1'b1; mif.mem_write = 1'b1; mif.mem_write_addr = 1'b1;
        tick(); strobes_off();
        rd(8'h99);                      // MAR now 6
        set_mar(8'h0A); rd(8'h46);

        // bus idle when not reading
        set_mar(8'h03); wr(8'hC3);
        #2 check_idle("idle_bus");

        // short load; coincident write strobe is dropped
        bus_drv = 8'hEE; bus_oe = 1'b1; mif.mem_write = 1'b1;
        start_load();
        strobes_off();
        check("load_ready", 32'(mif.load_ready), 32'h1);
        check("load_hold", 32'(mif.cpu_hold), 32'h1);
        done_q.push_back('{cnt: 4'd3, sum: 8'h66});
        load(8'h11, 1'b0);
        mif.load_start = 1'b1;          // ignored while loading
        load(8'h22, 1'b0);
        mif.load_start = 1'b0;
        load(8'h33, 1'b1);
        check("done_hold", 32'(mif.cpu_hold), 32'h1);
        check("done_ready", 32'(mif.load_ready), 32'h0);
        tick();
        check("hold_released", 32'(mif.cpu_hold), 32'h0);
        // loader byte outside LOAD is dropped
        load(8'hDD, 1'b0);
        rd(8'h11);                      // MAR cleared by DONE
        set_mar(8'h01); rd(8'h22);
        set_mar(8'h02); rd(8'h33);
        set_mar(8'h03); rd(8'hC3);

        // full 16-byte load without load_last
        start_load();
        done_q.push_back('{cnt: 4'd0, sum: 8'h78});
        for (int i = 0; i < 16; i++) load(8'(i), 1'b0);
        tick();
        check("full_hold_released", 32'(mif.cpu_hold), 32'h0);
        set_mar(8'h0F); rd(8'h0F);
        set_mar(8'h05); rd(8'h05);

        // reset in the middle of a load
        start_load();
        load(8'hA1, 1'b0);
        load(8'hA2, 1'b0);
        mif.load_valid = 1'b1; mif.load_data = 8'hA3;
        #2 rst_n = 1'b0;
        #1;
        check("abort_ready", 32'(mif.load_ready), 32'h0);
        check("abort_hold", 32'(mif.cpu_hold), 32'h0);
        check("abort_count", 32'(mif.load_count), 32'h0);
        mif.load_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        rd(8'hA1);
        set_mar(8'h01); rd(8'hA2);
        set_mar(8'h02); rd(8'h02);

`ifdef LOADER_CHECKSUM_EN
        start_load();
        done_q.push_back('{cnt: 4'd3, sum: 8'h00});
        load(8'h80, 1'b0); load(8'h90, 1'b0); load(8'hF0, 1'b1);
        tick(); tick();
        check("sum_hold", 32'(mif.load_sum), 32'h00);
        start_load();
        done_q.push_back('{cnt: 4'd1, sum: 8'h01});
        load(8'h01, 1'b1);
        tick(); tick();
        check("sum_hold2", 32'(mif.load_sum), 32'h01);
`endif

        tick(); tick();
        check("rd_q_drained", 32'(rd_q.size()), 32'h0);
        check("done_q_drained", 32'(done_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
